ysyx_23060062_mem_responder: RTL and testbench

Memory-side responder for the core's fetch/load/store port. It accepts one request at a time from the core (instruction fetch or data load/store) and answers after a fixed, parameterised latency from an internal word-addressed array. It gives the core's memory read/write signalling a defined clocked handshake. It sits between the core top and the simulation/SoC memory, and serves as the bench model for the core's memory interface.

---
 rtl/ysyx_23060062_mem_responder.sv | 154 +++++++++++++++
 tb/tb_ysyx_23060062_mem_responder.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060062_mem_responder.sv
// Fixed-latency memory responder for the core fetch/load/store port.
// One outstanding request; word array with byte-lane stores and fault detection.
module ysyx_23060062_mem_responder #(
   parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
   parameter int          DEPTH_LOG2 = 10,
   parameter int          LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;

   logic [31:0] mem [DEPTH];

   logic [31:0]           offset;
   logic [31:0]           above;
   logic                  fault_now;
   logic [DEPTH_LOG2-1:0] idx_now;
   logic                  accept;

   logic                  wr_q, fault_q;
   logic [DEPTH_LOG2-1:0] idx_q;
   logic [31:0]           rdata_q, rdata_nxt;
   logic                  err_q, err_nxt;

   logic                  src_wr, src_fault;
   logic [DEPTH_LOG2-1:0] src_idx;
   logic                  enter_resp;

   // Unsigned subtraction: addresses below BASE_ADDR wrap high and fail the range test.
   always_comb begin
      offset    = req_addr - BASE_ADDR;
      above     = offset >> (DEPTH_LOG2 + 2);
      fault_now = (req_addr < BASE_ADDR) || (above != 32'd0) || (req_addr[1:0] != 2'b00);
      idx_now   = offset[DEPTH_LOG2+1:2];
      accept    = req_valid && (state == IDLE);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (LATENCY == 1) begin
                  state_nxt = RESP;
               end else begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 4'd1;
         end
         RESP: begin
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
      resp_rdata = rdata_q;
      resp_err   = err_q;
   end

   // Request latch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= 1'b0;
         fault_q <= 1'b0;
         idx_q   <= '0;
      end else if (accept) begin
         wr_q    <= req_write;
         fault_q <= fault_now;
         idx_q   <= idx_now;
      end
   end

   // With LATENCY==1 RESP is entered on the accept edge, so read from the live request.
   always_comb begin
      src_wr     = (state == IDLE) ? req_write : wr_q;
      src_fault  = (state == IDLE) ? fault_now : fault_q;
      src_idx    = (state == IDLE) ? idx_now   : idx_q;
      enter_resp = (state_nxt == RESP) && (state != RESP);
      rdata_nxt  = rdata_q;
      err_nxt    = err_q;
      if (enter_resp) begin
         rdata_nxt = (src_wr || src_fault) ? 32'd0 : mem[src_idx];
         err_nxt   = src_fault;
      end else if ((state == RESP) && resp_ready) begin
         rdata_nxt = 32'd0;
         err_nxt   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         rdata_q <= rdata_nxt;
         err_q   <= err_nxt;
      end
   end

   // Stores commit at the accept edge; the array is deliberately not reset.
   always_ff @(posedge clk) begin
      if (accept && req_write && !fault_now) begin
         for (int b = 0; b < 4; b++) begin
            if (req_wstrb[b]) mem[idx_now][8*b +: 8] <= req_wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060062_mem_responder.sv
// Scoreboard bench: four responders (LATENCY 2, 1, 15, 4) share one clock;
// a bench-side memory model produces every expected response.
module tb_ysyx_23060062_mem_responder;

   localparam int N = 4;
   localparam int LAT [N] = '{2, 1, 15, 4};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_n      [N];
   logic        req_valid  [N];
   logic        req_ready  [N];
   logic        req_write  [N];
   logic [31:0] req_addr   [N];
   logic [31:0] req_wdata  [N];
   logic [3:0]  req_wstrb  [N];
   logic        resp_valid [N];
   logic        resp_ready [N];
   logic [31:0] resp_rdata [N];
   logic        resp_err   [N];

   for (genvar g = 0; g < N; g++) begin : gen_dut
      ysyx_23060062_mem_responder #(
         .BASE_ADDR (32'h8000_0000),
         .DEPTH_LOG2(10),
         .LATENCY   (LAT[g])
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n[g]),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_write (req_write[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_wstrb (req_wstrb[g]),
         .resp_valid(resp_valid[g]),
         .resp_ready(resp_ready[g]),
         .resp_rdata(resp_rdata[g]),
         .resp_err  (resp_err[g])
      );
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] model [N][1024];
   int checks = 0;
   int errors = 0;

   // Drive one request, wait for its accept edge, push the model's expected response.
   task automatic send_req(input int i, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb, output int acc);
      exp_t e;
      logic [31:0] off;
      logic flt;
      int k;
      off     = addr - 32'h8000_0000;
      flt     = (addr < 32'h8000_0000) || (off >= 32'h0000_1000) || (addr[1:0] != 2'b00);
      e.rdata = 32'd0;
      e.err   = flt;
      if (!flt && wr) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[i][off[11:2]][8*b +: 8] = wdata[8*b +: 8];
      end else if (!flt) begin
         e.rdata = model[i][off[11:2]];
      end
      @(negedge clk);
      req_valid[i] = 1'b1;
      req_write[i] = wr;
      req_addr[i]  = addr;
      req_wdata[i] = wdata;
      req_wstrb[i] = strb;
      k = 0;
      while (!req_ready[i] && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (!req_ready[i]) begin
         checks++; errors++;
         $display("FAIL accept_timeout inst %0d addr %h", i, addr);
      end
      @(posedge clk);
      #1;
      acc = cyc;
      req_valid[i] = 1'b0;
      exp_q.push_back(e);
   endtask

   task automatic wait_valid(input int i);
      int k;
      k = 0;
      @(negedge clk);
      while (!resp_valid[i] && k < 40) begin
         @(negedge clk);
         k++;
      end
      if (!resp_valid[i]) begin
         checks++; errors++;
         $display("FAIL resp_timeout inst %0d", i);
      end
   endtask

   // Collect a response with resp_ready already high; hs is the handshake edge.
   task automatic recv(input int i, output logic [31:0] rd, output logic er, output int hs);
      wait_valid(i);
      rd = resp_rdata[i];
      er = resp_err[i];
      @(posedge clk);
      #1;
      hs = cyc;
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) begin
         rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_write[i] = 1'b0;
         req_addr[i] = 32'd0; req_wdata[i] = 32'd0; req_wstrb[i] = 4'd0; resp_ready[i] = 1'b1;
      end
      #12;
      for (int i = 0; i < N; i++) begin
         checks++;
         if (req_ready[i] !== 1'b1 || resp_valid[i] !== 1'b0 || resp_rdata[i] !== 32'd0 || resp_err[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_state inst %0d got rdy=%b vld=%b rd=%h err=%b want 1 0 0 0",
                     i, req_ready[i], resp_valid[i], resp_rdata[i], resp_err[i]);
         end
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
   endtask

   task automatic test_preload();
      logic [31:0] rd; logic er; int acc, hs; exp_t e;
      for (int k = 0; k < 1024; k++) begin
         send_req(0, 1'b1, 32'h8000_0000 + 32'(k * 4), 32'h1000_0000 ^ (32'(k) * 32'h9E37_79B9), 4'hF, acc);
         recv(0, rd, er, hs);
         e = exp_q.pop_front();
         checks++;
         if (rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL preload word %0d got %h/%b want %h/%b", k, rd, er, e.rdata, e.err);
         end
      end
   endtask

   task automatic test_store_load();
      logic [31:0] rd; logic er; int acc, hs; exp_t e;
      send_req(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, acc);
      recv(0, rd, er, hs);
      e = exp_q.pop_front();
      checks++;
      if (rd !== 32'd0 || er !== 1'b0 || hs - acc != 2) begin
         errors++;
         $display("FAIL store_resp got %h/%b lat %0d want 0/0 lat 2", rd, er, hs - acc);
      end
      send_req(0, 1'b0, 32'h8000_0010, 32'd0, 4'h0, acc);
      recv(0, rd, er, hs);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.rdata || rd !== 32'hDEAD_BEEF || er !== 1'b0 || hs - acc != 2) begin
         errors++;
         $display("FAIL load_after_store got %h/%b lat %0d want deadbeef/0 lat 2", rd, er, hs - acc);
      end
   endtask

   task automatic test_partial_strobe();
      logic [31:0] rd; logic er; int acc, hs; exp_t e;
      send_req(0, 1'b1, 32'h8000_0000, 32'h1122_3344, 4'hF, acc);
      recv(0, rd, er, hs);
      e = exp_q.pop_front();
      send_req(0, 1'b1, 32'h8000_0000, 32'hAABB_CCDD, 4'b0101, acc);
      recv(0, rd, er, hs);
      e = exp_q.pop_front();
      send_req(0, 1'b0, 32'h8000_0000, 32'd0, 4'h0, acc);
      recv(0, rd, er, hs);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.rdata || rd !== 32'h11BB_33DD || er !== 1'b0) begin
         errors++;
         $display("FAIL partial_strobe got %h/%b want 11bb33dd/0", rd, er);
      end
      send_req(0, 1'b1, 32'h8000_0008, 32'h5555_5555, 4'h0, acc);
      recv(0, rd, er, hs);
      e = exp_q.pop_front();
      send_req(0, 1'b0, 32'h8000_0008, 32'd0, 4'h0, acc);
      recv(0, rd, er, hs);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.rdata || er !== 1'b0) begin
         errors++;
         $display("FAIL zero_strobe got %h/%b want %h/0", rd, er, e.rdata);
      end
   endtask

   task automatic test_faults();
      logic [31:0] rd; logic er; int acc, hs, bad; exp_t e;
      logic [31:0] addrs [6];
      addrs = '{32'h8000_0002, 32'h7FFF_FFFC, 32'h8000_1000, 32'h8000_0FFC, 32'hFFFF_FFFC, 32'h8000_0FFF};
      for (int k = 0; k < 6; k++) begin
         send_req(0, 1'b0, addrs[k], 32'd0, 4'h0, acc);
         recv(0, rd, er, hs);
         e = exp_q.pop_front();
         checks++;
         if (rd !== e.rdata || er !== e.err) begin
            errors++;
            $display("FAIL fault_load addr %h got %h/%b want %h/%b", addrs[k], rd, er, e.rdata, e.err);
         end
      end
      send_req(0, 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, acc);
      recv(0, rd, er, hs);
      e = exp_q.pop_front();
      checks++;
      if (rd !== 32'd0 || er !== 1'b1) begin
         errors++;
         $display("FAIL fault_store_resp got %h/%b want 0/1", rd, er);
      end
      send_req(0, 1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, acc);
      recv(0, rd, er, hs);
      e = exp_q.pop_front();
      bad = 0;
      for (int k = 0; k < 1024; k++)
         if (gen_dut[0].u_dut.mem[k] !== model[0][k]) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL fault_store_array got %0d changed words want 0", bad);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] r0; logic e0; int acc; exp_t e;
      resp_ready[0] = 1'b0;
      send_req(0, 1'b0, 32'h8000_0004, 32'd0, 4'h0, acc);
      wait_valid(0);
      r0 = resp_rdata[0];
      e0 = resp_err[0];
      e = exp_q.pop_front();
      checks++;
      if (r0 !== e.rdata || e0 !== e.err) begin
         errors++;
         $display("FAIL bp_data got %h/%b want %h/%b", r0, e0, e.rdata, e.err);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== r0 || resp_err[0] !== e0 || req_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cycle %0d got vld=%b rd=%h err=%b rdy=%b want 1 %h %b 0",
                     c, resp_valid[0], resp_rdata[0], resp_err[0], req_ready[0], r0, e0);
         end
      end
      resp_ready[0] = 1'b1;
      #1;
      checks++;
      if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_pre_handshake got rdy=%b vld=%b want 0 1", req_ready[0], resp_valid[0]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL bp_post_handshake got vld=%b rdy=%b want 0 1", resp_valid[0], req_ready[0]);
      end
   endtask

   task automatic test_latency_sweep(input int i);
      logic [31:0] rd; logic er; int acc, prev, hs; exp_t e;
      send_req(i, 1'b1, 32'h8000_0040, 32'h0BAD_CAFE, 4'hF, acc);
      recv(i, rd, er, hs);
      e = exp_q.pop_front();
      send_req(i, 1'b1, 32'h8000_0FFC, 32'h7357_0001, 4'hF, acc);
      recv(i, rd, er, hs);
      e = exp_q.pop_front();
      checks++;
      if (hs - acc != LAT[i] || rd !== 32'd0 || er !== 1'b0) begin
         errors++;
         $display("FAIL sweep_store inst %0d got lat %0d %h/%b want lat %0d 0/0", i, hs - acc, rd, er, LAT[i]);
      end
      prev = -1;
      for (int k = 0; k < 4; k++) begin
         send_req(i, 1'b0, k[0] ? 32'h8000_0FFC : 32'h8000_0040, 32'd0, 4'h0, acc);
         recv(i, rd, er, hs);
         e = exp_q.pop_front();
         checks++;
         if (rd !== e.rdata || er !== 1'b0 || hs - acc != LAT[i] || (prev >= 0 && acc - prev != LAT[i] + 1)) begin
            errors++;
            $display("FAIL sweep_load inst %0d k %0d got %h lat %0d gap %0d want %h lat %0d gap %0d",
                     i, k, rd, hs - acc, acc - prev, e.rdata, LAT[i], LAT[i] + 1);
         end
         prev = acc;
      end
   endtask

   task automatic test_reset_mid_wait();
      logic [31:0] rd; logic er; int acc, hs; exp_t e; logic rose;
      send_req(3, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'hF, acc);
      e = exp_q.pop_back();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n[3] = 1'b0;
      #1;
      checks++;
      if (req_ready[3] !== 1'b1 || resp_valid[3] !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got rdy=%b vld=%b want 1 0", req_ready[3], resp_valid[3]);
      end
      @(negedge clk);
      rst_n[3] = 1'b1;
      rose = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (resp_valid[3] !== 1'b0) rose = 1'b1;
      end
      checks++;
      if (rose) begin
         errors++;
         $display("FAIL dropped_resp got resp_valid=1 want 0");
      end
      send_req(3, 1'b0, 32'h8000_0020, 32'd0, 4'h0, acc);
      recv(3, rd, er, hs);
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.rdata || rd !== 32'hCAFE_F00D || er !== 1'b0 || hs - acc != 4) begin
         errors++;
         $display("FAIL store_survives_reset got %h/%b lat %0d want cafef00d/0 lat 4", rd, er, hs - acc);
      end
   endtask

   initial begin
      test_reset();
      test_preload();
      test_store_load();
      test_partial_strobe();
      test_faults();
      test_backpressure();
      test_latency_sweep(1);
      test_latency_sweep(2);
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
